// File: rtl/ddr_stream_wr_master.sv
// Write-channel bus master: drains a 32-bit stream into DDR3 as a series of bursts,
// one burst in flight at a time, and pulses done once the last beat is accepted.
module ddr_stream_wr_master #(
    parameter int MAX_BURST = 256,
    parameter int CNT_W     = 24
) (
    input  logic             BUS_CLK,
    input  logic             BUS_RST,
    input  logic             cmd_start,
    input  logic [31:0]      cmd_addr,
    input  logic [CNT_W-1:0] cmd_words,
    output logic             busy,
    output logic             done,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      MASTER_WR_ADDR,
    output logic [7:0]       MASTER_WR_LEN,
    output logic             MASTER_WR_ADDR_VALID,
    input  logic             MASTER_WR_ADDR_READY,
    output logic [31:0]      MASTER_WR_DATA,
    output logic [3:0]       MASTER_WR_STRB,
    output logic             MASTER_WR_DATA_VALID,
    input  logic             MASTER_WR_DATA_READY,
    output logic             MASTER_WR_DATA_LAST
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, NEXT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [7:0]       beat_cnt;
    logic [CNT_W-1:0] beats_cmd;
    logic [CNT_W-1:0] beats_rem;
    logic             in_data;

    function automatic logic [CNT_W-1:0] burst_of(input logic [CNT_W-1:0] rem);
        burst_of = (rem > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : rem;
    endfunction

    assign beats_cmd = burst_of(cmd_words);
    assign beats_rem = burst_of(remaining);

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state                <= IDLE;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            MASTER_WR_ADDR_VALID <= 1'b0;
            MASTER_WR_ADDR       <= '0;
            MASTER_WR_LEN        <= '0;
            remaining            <= '0;
            beat_cnt             <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        if (cmd_words != '0) begin
                            state                <= ADDR;
                            busy                 <= 1'b1;
                            MASTER_WR_ADDR_VALID <= 1'b1;
                            MASTER_WR_ADDR       <= cmd_addr;
                            MASTER_WR_LEN        <= 8'(beats_cmd - CNT_W'(1));
                            remaining            <= cmd_words - beats_cmd;
                            beat_cnt             <= '0;
                        end else begin
                            // Empty command completes without touching the bus
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (MASTER_WR_ADDR_READY) begin
                        MASTER_WR_ADDR_VALID <= 1'b0;
                        state                <= DATA;
                    end
                end
                DATA: begin
                    if (s_valid && MASTER_WR_DATA_READY) begin
                        if (beat_cnt == MASTER_WR_LEN) state <= NEXT;
                        else beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                NEXT: begin
                    if (remaining == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state                <= ADDR;
                        MASTER_WR_ADDR_VALID <= 1'b1;
                        MASTER_WR_ADDR       <= MASTER_WR_ADDR + 32'(MASTER_WR_LEN) + 32'd1;
                        MASTER_WR_LEN        <= 8'(beats_rem - CNT_W'(1));
                        remaining            <= remaining - beats_rem;
                        beat_cnt             <= '0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stream is wired straight to the data channel, but only while a burst is open
    assign in_data              = (state == DATA);
    assign MASTER_WR_DATA       = in_data ? s_data : '0;
    assign MASTER_WR_DATA_VALID = in_data & s_valid;
    assign s_ready              = in_data & MASTER_WR_DATA_READY;
    assign MASTER_WR_DATA_LAST  = in_data && (beat_cnt == MASTER_WR_LEN);
    assign MASTER_WR_STRB       = 4'hF;

endmodule

// File: tb/tb_ddr_stream_wr_master.sv
// Bench for ddr_stream_wr_master: random stream/slave behaviour checked against a
// burst-list and word-queue model of the command.
module tb_ddr_stream_wr_master;
    localparam int CNT_W = 24;

    logic             BUS_CLK = 1'b0;
    logic             BUS_RST;
    logic             cmd_start;
    logic [31:0]      cmd_addr;
    logic [CNT_W-1:0] cmd_words;
    logic             busy, done;
    logic [31:0]      s_data;
    logic             s_valid, s_ready;
    logic [31:0]      MASTER_WR_ADDR;
    logic [7:0]       MASTER_WR_LEN;
    logic             MASTER_WR_ADDR_VALID, MASTER_WR_ADDR_READY;
    logic [31:0]      MASTER_WR_DATA;
    logic [3:0]       MASTER_WR_STRB;
    logic             MASTER_WR_DATA_VALID, MASTER_WR_DATA_READY, MASTER_WR_DATA_LAST;

    int checks   = 0;
    int failures = 0;

    ddr_stream_wr_master #(.MAX_BURST(256), .CNT_W(CNT_W)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
        .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .busy(busy), .done(done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .MASTER_WR_ADDR(MASTER_WR_ADDR), .MASTER_WR_LEN(MASTER_WR_LEN),
        .MASTER_WR_ADDR_VALID(MASTER_WR_ADDR_VALID), .MASTER_WR_ADDR_READY(MASTER_WR_ADDR_READY),
        .MASTER_WR_DATA(MASTER_WR_DATA), .MASTER_WR_STRB(MASTER_WR_STRB),
        .MASTER_WR_DATA_VALID(MASTER_WR_DATA_VALID), .MASTER_WR_DATA_READY(MASTER_WR_DATA_READY),
        .MASTER_WR_DATA_LAST(MASTER_WR_DATA_LAST)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_done"},       done, 0);
        chk({tag, "_s_ready"},    s_ready, 0);
        chk({tag, "_addr_valid"}, MASTER_WR_ADDR_VALID, 0);
        chk({tag, "_data_valid"}, MASTER_WR_DATA_VALID, 0);
        chk({tag, "_last"},       MASTER_WR_DATA_LAST, 0);
        chk({tag, "_addr"},       MASTER_WR_ADDR, 0);
        chk({tag, "_len"},        MASTER_WR_LEN, 0);
    endtask

    // Runs one command. abort_at >= 0 applies BUS_RST once that many beats are accepted.
    task automatic run_cmd(input logic [31:0] a, input int w, input bit bp,
                           input bit extra_start, input int abort_at);
        logic [31:0] ea[$];
        int          el[$];
        logic [31:0] data_q[$];
        logic [31:0] na, h_addr;
        logic [7:0]  h_len;
        int          rem, b, beats, bib, cur_len, cyc;
        bit          in_burst, hold, finished, aborted;

        na = a; rem = w;
        while (rem > 0) begin
            b = (rem > 256) ? 256 : rem;
            ea.push_back(na);
            el.push_back(b - 1);
            na = na + 32'(b);
            rem -= b;
        end
        for (int i = 0; i < w; i++) data_q.push_back($urandom);

        beats = 0; bib = 0; cur_len = 0;
        in_burst = 0; hold = 0; finished = 0; aborted = 0;
        h_addr = '0; h_len = '0;

        @(negedge BUS_CLK);
        cmd_start = 1'b1; cmd_addr = a; cmd_words = CNT_W'(w);
        s_valid = 1'b0; MASTER_WR_ADDR_READY = 1'b0; MASTER_WR_DATA_READY = 1'b0;

        for (cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge BUS_CLK);
            cmd_start = extra_start && (cyc == 6);
            cmd_addr  = extra_start ? 32'hDEAD_0000 : a;
            cmd_words = CNT_W'(5);
            s_valid   = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data    = (beats < w) ? data_q[beats] : $urandom;
            MASTER_WR_ADDR_READY = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            MASTER_WR_DATA_READY = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (done) begin
                chk("done_busy_low", busy, 0);
                chk("done_beats", beats, w);
                chk("done_bursts_left", ea.size(), 0);
                chk("done_in_burst", in_burst, 0);
                if (w == 0) chk("zero_done_latency", cyc, 0);
                finished = 1;
            end else begin
                chk("busy", busy, 1);
                chk("s_ready", s_ready, in_burst & MASTER_WR_DATA_READY);
                chk("data_valid", MASTER_WR_DATA_VALID, in_burst & s_valid);
                chk("last", MASTER_WR_DATA_LAST, in_burst && (bib == cur_len));
                if (in_burst) chk("addr_valid_in_data", MASTER_WR_ADDR_VALID, 0);
                if (MASTER_WR_DATA_VALID && MASTER_WR_DATA_READY && in_burst) begin
                    if (beats < w) chk("wr_data", MASTER_WR_DATA, data_q[beats]);
                    else chk("beat_overflow", beats, w - 1);
                    chk("wr_strb", MASTER_WR_STRB, 4'hF);
                    beats++;
                    if (bib == cur_len) in_burst = 0;
                    bib++;
                end else if (MASTER_WR_ADDR_VALID) begin
                    if (hold) begin
                        chk("addr_hold", MASTER_WR_ADDR, h_addr);
                        chk("len_hold", MASTER_WR_LEN, h_len);
                    end
                    if (MASTER_WR_ADDR_READY) begin
                        if (ea.size() == 0) chk("extra_burst", ea.size(), 1);
                        else begin
                            chk("burst_addr", MASTER_WR_ADDR, ea.pop_front());
                            chk("burst_len", MASTER_WR_LEN, el.pop_front());
                            in_burst = 1; bib = 0; cur_len = int'(MASTER_WR_LEN);
                        end
                        hold = 0;
                    end else begin
                        hold = 1; h_addr = MASTER_WR_ADDR; h_len = MASTER_WR_LEN;
                    end
                end
                if (abort_at >= 0 && beats == abort_at) begin
                    @(negedge BUS_CLK);
                    BUS_RST = 1'b1; cmd_start = 1'b0; s_valid = 1'b1;
                    MASTER_WR_ADDR_READY = 1'b1; MASTER_WR_DATA_READY = 1'b1;
                    @(posedge BUS_CLK);
                    #1;
                    check_reset_outputs("abort");
                    chk("abort_data", MASTER_WR_DATA, 0);
                    @(negedge BUS_CLK);
                    BUS_RST = 1'b0;
                    aborted = 1; finished = 1;
                end
            end
        end
        chk("timeout", finished, 1);

        if (!aborted) begin
            @(negedge BUS_CLK);
            cmd_start = 1'b0; s_valid = 1'b0;
            #1;
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_addr_valid", MASTER_WR_ADDR_VALID, 0);
        end
    endtask

    initial begin
        BUS_RST = 1'b1; cmd_start = 1'b0; cmd_addr = '0; cmd_words = '0;
        s_data = '0; s_valid = 1'b0;
        MASTER_WR_ADDR_READY = 1'b0; MASTER_WR_DATA_READY = 1'b0;
        repeat (3) @(negedge BUS_CLK);
        #1;
        check_reset_outputs("reset");
        chk("reset_strb", MASTER_WR_STRB, 4'hF);
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;

        run_cmd(32'h0000_0100, 4, 0, 0, -1);
        run_cmd(32'h0000_2000, 600, 0, 0, -1);
        run_cmd(32'h0000_0300, 0, 0, 0, -1);
        run_cmd($urandom, 37, 1, 0, -1);
        run_cmd(32'hFFFF_FF80, 300, 1, 0, -1);
        for (int k = 0; k < 3; k++) run_cmd($urandom, int'($urandom_range(1, 520)), 1, 0, -1);
        run_cmd(32'h0000_4000, 20, 1, 1, -1);
        run_cmd(32'h0000_5000, 600, 0, 0, 10);
        run_cmd(32'h0000_6000, 5, 1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
